// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the direct-mapped, write-through data cache.
package dcache_pkg;

  localparam int NUM_LINES = 16;
  localparam int INDEX_W   = $clog2(NUM_LINES);
  localparam int TAG_W     = 30 - INDEX_W;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE
  } state_t;

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage for the cache: one combinational read port, one write port,
// and a synchronous clear of every valid bit.
module dcache_array #(
  parameter int NUM_LINES = dcache_pkg::NUM_LINES,
  parameter int INDEX_W   = $clog2(NUM_LINES),
  parameter int TAG_W     = 30 - INDEX_W
) (
  input  logic               clk,
  input  logic               clear,
  input  logic [INDEX_W-1:0] rdIdx,
  output logic               rdValid,
  output logic [TAG_W-1:0]   rdTag,
  output logic [31:0]        rdData,
  input  logic               we,
  input  logic [INDEX_W-1:0] wrIdx,
  input  logic [TAG_W-1:0]   wrTag,
  input  logic [31:0]        wrData
);
  import dcache_pkg::*;

  logic [NUM_LINES-1:0] validBits;
  logic [TAG_W-1:0]     tagMem  [NUM_LINES];
  logic [31:0]          dataMem [NUM_LINES];

  // Clear wins over a same-cycle write so an abandoned fill can never leave a valid line.
  always_ff @(posedge clk) begin
    if (clear) begin
      validBits <= '0;
    end else if (we) begin
      validBits[wrIdx] <= 1'b1;
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; the valid bits alone
  // decide whether their contents mean anything, and unreset arrays map to plain RAM.
  always_ff @(posedge clk) begin
    if (we && !clear) begin
      tagMem[wrIdx]  <= wrTag;
      dataMem[wrIdx] <= wrData;
    end
  end

  assign rdValid = validBits[rdIdx];
  assign rdTag   = tagMem[rdIdx];
  assign rdData  = dataMem[rdIdx];

endmodule

// File: rtl/dcache.sv
// Direct-mapped, one-word-line data cache: write-through, no-write-allocate, blocking
// misses via a simple req/ack backing-memory handshake, plus saturating hit/miss counters.
module dcache #(
  parameter int NUM_LINES = dcache_pkg::NUM_LINES,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             DataRE,
  input  logic             DataWE,
  input  logic [31:0]      DataA,
  input  logic [31:0]      DataWD,
  output logic [31:0]      DataRD,
  output logic             Stall,
  output logic             MemReq,
  output logic             MemWE,
  output logic [31:0]      MemA,
  output logic [31:0]      MemWD,
  input  logic [31:0]      MemRD,
  input  logic             MemAck,
  output logic [CNT_W-1:0] HitCount,
  output logic [CNT_W-1:0] MissCount
);
  import dcache_pkg::*;

  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = 30 - INDEX_W;

  state_t             state, nextState;
  logic [INDEX_W-1:0] lineIdx;
  logic [TAG_W-1:0]   lineTag;
  logic               rdValid;
  logic [TAG_W-1:0]   rdTag;
  logic [31:0]        rdData;
  logic               hit;
  logic               arrWe;
  logic [31:0]        arrWData;
  logic               hitEvt, missEvt;

  assign lineIdx = DataA[2 +: INDEX_W];
  assign lineTag = DataA[31 -: TAG_W];
  assign hit     = rdValid && (rdTag == lineTag);

  dcache_array #(
    .NUM_LINES(NUM_LINES),
    .INDEX_W  (INDEX_W),
    .TAG_W    (TAG_W)
  ) u_array (
    .clk    (clk),
    .clear  (reset),
    .rdIdx  (lineIdx),
    .rdValid(rdValid),
    .rdTag  (rdTag),
    .rdData (rdData),
    .we     (arrWe),
    .wrIdx  (lineIdx),
    .wrTag  (lineTag),
    .wrData (arrWData)
  );

  // NOTE: state and counters use non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    nextState = state;
    Stall     = 1'b0;
    MemReq    = 1'b0;
    MemWE     = 1'b0;
    arrWe     = 1'b0;
    arrWData  = DataWD;
    hitEvt    = 1'b0;
    missEvt   = 1'b0;
    case (state)
      IDLE: begin
        if (DataWE) begin
          Stall     = 1'b1;
          MemReq    = 1'b1;
          MemWE     = 1'b1;
          nextState = WRITE;
        end else if (DataRE) begin
          if (hit) begin
            hitEvt = 1'b1;
          end else begin
            Stall     = 1'b1;
            MemReq    = 1'b1;
            missEvt   = 1'b1;
            nextState = FILL;
          end
        end
      end
      FILL: begin
        Stall  = 1'b1;
        MemReq = 1'b1;
        if (MemAck) begin
          arrWe     = 1'b1;
          arrWData  = MemRD;
          nextState = IDLE;
        end
      end
      WRITE: begin
        Stall  = 1'b1;
        MemReq = 1'b1;
        MemWE  = 1'b1;
        // The memory write is done on the ack, so the core is released that same cycle.
        if (MemAck) begin
          Stall     = 1'b0;
          arrWe     = hit;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
    if (reset) begin
      Stall   = 1'b0;
      MemReq  = 1'b0;
      MemWE   = 1'b0;
      arrWe   = 1'b0;
      hitEvt  = 1'b0;
      missEvt = 1'b0;
    end
  end

  assign MemA   = {DataA[31:2], 2'b00};
  assign MemWD  = DataWD;
  assign DataRD = (DataRE && !reset) ? rdData : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      HitCount  <= '0;
      MissCount <= '0;
    end else begin
      if (hitEvt && (HitCount != '1)) begin
        HitCount <= HitCount + 1'b1;
      end
      if (missEvt && (MissCount != '1)) begin
        MissCount <= MissCount + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dcache.sv
// Directed bench for dcache: cold miss, hits, write hit/miss, reset mid-fill, RE+WE priority.
// Counters are built 2 bits wide so hit-counter saturation at 3 is exercised.
module tb_dcache;

  logic        clk = 1'b0;
  logic        reset;
  logic        DataRE, DataWE;
  logic [31:0] DataA, DataWD, DataRD;
  logic        Stall, MemReq, MemWE;
  logic [31:0] MemA, MemWD, MemRD;
  logic        MemAck;
  logic [1:0]  HitCount, MissCount;

  int vectors    = 0;
  int miscompares = 0;

  dcache #(.NUM_LINES(16), .CNT_W(2)) dut (
    .clk      (clk),
    .reset    (reset),
    .DataRE   (DataRE),
    .DataWE   (DataWE),
    .DataA    (DataA),
    .DataWD   (DataWD),
    .DataRD   (DataRD),
    .Stall    (Stall),
    .MemReq   (MemReq),
    .MemWE    (MemWE),
    .MemA     (MemA),
    .MemWD    (MemWD),
    .MemRD    (MemRD),
    .MemAck   (MemAck),
    .HitCount (HitCount),
    .MissCount(MissCount)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; DataRE = 1'b0; DataWE = 1'b0;
    DataA = '0; DataWD = '0; MemRD = '0; MemAck = 1'b0;
    tick(); tick();
    // Outputs are forced quiet during reset even with a read pending.
    DataRE = 1'b1; DataA = 32'h40; #1;
    check("rst_stall",  32'(Stall),     32'd0);
    check("rst_memreq", 32'(MemReq),    32'd0);
    check("rst_memwe",  32'(MemWE),     32'd0);
    check("rst_datard", DataRD,         32'd0);
    check("rst_hit",    32'(HitCount),  32'd0);
    check("rst_miss",   32'(MissCount), 32'd0);

    // Cold read miss of 0x40; ack 3 cycles after the request.
    tick(); reset = 1'b0; DataRE = 1'b0; #1;
    check("idle_stall", 32'(Stall), 32'd0);
    check("idle_rd0",   DataRD,     32'd0);
    tick(); DataRE = 1'b1; DataA = 32'h40; #1;
    check("miss_stall_c0", 32'(Stall),  32'd1);
    check("miss_req_c0",   32'(MemReq), 32'd1);
    check("miss_we_c0",    32'(MemWE),  32'd0);
    check("miss_mema",     MemA,        32'h40);
    tick();
    check("miss_stall_c1", 32'(Stall),  32'd1);
    check("miss_req_c1",   32'(MemReq), 32'd1);
    tick();
    check("miss_stall_c2", 32'(Stall), 32'd1);
    tick(); MemAck = 1'b1; MemRD = 32'hDEADBEEF; #1;
    check("miss_stall_ack", 32'(Stall), 32'd1);
    tick(); MemAck = 1'b0; MemRD = '0; #1;
    check("fill_hit_stall", 32'(Stall),  32'd0);
    check("fill_hit_data",  DataRD,      32'hDEADBEEF);
    check("fill_hit_req",   32'(MemReq), 32'd0);
    tick(); DataRE = 1'b0; #1;
    check("cold_hitcnt",  32'(HitCount),  32'd1);
    check("cold_misscnt", 32'(MissCount), 32'd1);
    check("rd_off_zero",  DataRD,         32'd0);

    // Repeat read, with byte-offset bits set (they must be ignored).
    tick(); DataRE = 1'b1; DataA = 32'h43; #1;
    check("hit_stall", 32'(Stall),  32'd0);
    check("hit_data",  DataRD,      32'hDEADBEEF);
    check("hit_req",   32'(MemReq), 32'd0);
    tick(); DataRE = 1'b0; #1;
    check("hit_hitcnt", 32'(HitCount), 32'd2);

    // Write hit 0x40, then read back.
    tick(); DataWE = 1'b1; DataA = 32'h40; DataWD = 32'h12345678; #1;
    check("wr_stall_c0", 32'(Stall), 32'd1);
    tick();
    check("wr_req",   32'(MemReq), 32'd1);
    check("wr_we",    32'(MemWE),  32'd1);
    check("wr_wd",    MemWD,       32'h12345678);
    check("wr_stall", 32'(Stall),  32'd1);
    tick(); MemAck = 1'b1; #1;
    check("wr_ack_stall", 32'(Stall), 32'd0);
    tick(); MemAck = 1'b0; DataWE = 1'b0; DataRE = 1'b1; #1;
    check("wr_rb_stall", 32'(Stall), 32'd0);
    check("wr_rb_data",  DataRD,     32'h12345678);
    tick(); DataRE = 1'b0; #1;
    check("wr_hitcnt",  32'(HitCount),  32'd3);
    check("wr_misscnt", 32'(MissCount), 32'd1);

    // Write miss 0x80 (same index, other tag): line 0 must keep 0x40 data.
    tick(); DataWE = 1'b1; DataA = 32'h80; DataWD = 32'hCAFEF00D; #1;
    tick();
    check("wm_wd", MemWD, 32'hCAFEF00D);
    check("wm_a",  MemA,  32'h80);
    tick(); MemAck = 1'b1; #1;
    tick(); MemAck = 1'b0; DataWE = 1'b0; DataRE = 1'b1; DataA = 32'h40; #1;
    check("wm_rb_stall", 32'(Stall), 32'd0);
    check("wm_rb_data",  DataRD,     32'h12345678);
    tick(); DataRE = 1'b0; #1;
    // Fourth hit on a 2-bit counter: saturated at 3.
    check("sat_hitcnt",  32'(HitCount),  32'd3);
    check("wm_misscnt",  32'(MissCount), 32'd1);

    // Read miss 0x400, reset one cycle into FILL, then a late ack.
    tick(); DataRE = 1'b1; DataA = 32'h400; #1;
    check("rm_stall", 32'(Stall), 32'd1);
    tick();
    check("rm_fill_req", 32'(MemReq),    32'd1);
    check("rm_misscnt",  32'(MissCount), 32'd2);
    reset = 1'b1; DataRE = 1'b0; #1;
    check("rm_rst_req",   32'(MemReq), 32'd0);
    check("rm_rst_stall", 32'(Stall),  32'd0);
    tick(); reset = 1'b0; MemAck = 1'b1; MemRD = 32'h00000BAD; #1;
    check("late_ack_req",   32'(MemReq), 32'd0);
    check("late_ack_stall", 32'(Stall),  32'd0);
    check("late_hitcnt",    32'(HitCount), 32'd0);
    tick(); MemAck = 1'b0; MemRD = '0; DataRE = 1'b1; DataA = 32'h40; #1;
    check("post_rst_miss", 32'(Stall),  32'd1);
    check("post_rst_req",  32'(MemReq), 32'd1);
    tick();
    check("post_rst_misscnt", 32'(MissCount), 32'd1);
    MemAck = 1'b1; MemRD = 32'h55AA55AA; #1;
    tick(); MemAck = 1'b0; MemRD = '0; #1;
    check("refill_data",  DataRD,     32'h55AA55AA);
    check("refill_stall", 32'(Stall), 32'd0);
    tick(); DataRE = 1'b0; #1;
    check("refill_hitcnt", 32'(HitCount), 32'd1);

    // Read and write together: treated as a write, counters untouched.
    tick(); DataRE = 1'b1; DataWE = 1'b1; DataA = 32'h40; DataWD = 32'h0F0F0F0F; #1;
    check("rw_stall", 32'(Stall), 32'd1);
    check("rw_we_c0", 32'(MemWE), 32'd1);
    tick();
    check("rw_we",  32'(MemWE), 32'd1);
    check("rw_wd",  MemWD,      32'h0F0F0F0F);
    MemAck = 1'b1; #1;
    tick(); MemAck = 1'b0; DataWE = 1'b0; DataRE = 1'b0; #1;
    check("rw_hitcnt",  32'(HitCount),  32'd1);
    check("rw_misscnt", 32'(MissCount), 32'd1);
    DataRE = 1'b1; #1;
    check("rw_rb_data", DataRD, 32'h0F0F0F0F);
    tick(); DataRE = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
